// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width converters.
package stream_pkg;

    typedef enum logic [0:0] {IDLE, SEND} state_t;

    // Widest lane mask the helpers below accept.
    localparam int unsigned MAX_LANES = 64;

    function automatic int unsigned lane_idx_w(input int unsigned ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic logic onehot_count_is_one(input logic [MAX_LANES-1:0] mask);
        return (mask != '0) && ((mask & (mask - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/lane_priority_enc.sv
// Lowest-set-bit encoder for a lane mask, with any-set and exactly-one-set flags.
module lane_priority_enc
    import stream_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = lane_idx_w(N)
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             one
);

    // Scan downwards so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign any = |mask;
    assign one = onehot_count_is_one(MAX_LANES'(mask));

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each beat in ascending order.
// Optional STREAM_DOWNSIZE_BYPASS_EN loads the next beat as the final lane leaves.
module stream_downsize
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 4,
    parameter int unsigned T_DATA_RATIO = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
);

    localparam int unsigned IDX_W = lane_idx_w(T_DATA_RATIO);

    state_t                  state;
    logic [T_DATA_WIDTH-1:0] data_buf [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem;
    logic                    last_r;

    logic [IDX_W-1:0]        lane;
    logic                    rem_any;
    logic                    rem_one;
    logic                    m_hs;
    logic                    s_acc;
    logic                    keep_nz;

    lane_priority_enc #(
        .N     (T_DATA_RATIO),
        .IDX_W (IDX_W)
    ) u_rem_enc (
        .mask (rem),
        .idx  (lane),
        .any  (rem_any),
        .one  (rem_one)
    );

    assign m_valid_o = (state == SEND) && rem_any;
    assign m_hs      = m_valid_o && m_ready_i;
    assign m_last_o  = m_valid_o && last_r && rem_one;
    assign m_data_o  = m_valid_o ? data_buf[lane] : '0;

`ifdef STREAM_DOWNSIZE_BYPASS_EN
    assign s_ready_o = !rst_n && ((state == IDLE) || (m_hs && rem_one));
`else
    assign s_ready_o = !rst_n && (state == IDLE);
`endif

    assign s_acc   = s_valid_i && s_ready_o;
    assign keep_nz = (s_keep_i != '0);

    // Zero-keep beats are accepted but never loaded, so they produce no output.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            data_buf <= '{default: '0};
            rem      <= '0;
            last_r   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_acc && keep_nz) begin
                        data_buf <= s_data_i;
                        rem      <= s_keep_i;
                        last_r   <= s_last_i;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (m_hs) begin
                        rem[lane] <= 1'b0;
                        if (rem_one) begin
`ifdef STREAM_DOWNSIZE_BYPASS_EN
                            if (s_acc && keep_nz) begin
                                data_buf <= s_data_i;
                                rem      <= s_keep_i;
                                last_r   <= s_last_i;
                            end else begin
                                state <= IDLE;
                            end
`else
                            state <= IDLE;
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize: queue-based word model plus directed literal checks.
module tb_stream_downsize;

    localparam int unsigned W = 4;
    localparam int unsigned R = 2;

`ifdef STREAM_DOWNSIZE_BYPASS_EN
    localparam int EXP_SPAN = 8;
    localparam logic EXP_RDY_N2 = 1'b1;
`else
    localparam int EXP_SPAN = 11;
    localparam logic EXP_RDY_N2 = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] s_data [R];
    logic [R-1:0] s_keep = '0;
    logic         s_last = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         m_valid;
    logic         m_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    stream_downsize #(
        .T_DATA_WIDTH (W),
        .T_DATA_RATIO (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data_i  (s_data),
        .s_keep_i  (s_keep),
        .s_last_i  (s_last),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: every word still owed downstream, as {last, data}, oldest first.
    logic [W:0]   q[$];
    logic         hs_p, acc_p, acc_last;
    logic [R-1:0] acc_keep;
    logic [W-1:0] acc_data [R];
    bit           tp_on = 0;
    int           cyc = 0, vcnt = 0, first_v = -1, last_hs = -1;
    bit           rand_rdy = 0;

    always @(negedge clk) begin
        logic exp_rdy;
        if (rst_n) begin
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_s_ready", s_ready, 0);
            hs_p  = 0;
            acc_p = 0;
        end else begin
`ifdef STREAM_DOWNSIZE_BYPASS_EN
            exp_rdy = (q.size() == 0) || (q.size() == 1 && m_ready);
`else
            exp_rdy = (q.size() == 0);
`endif
            chk("m_valid", m_valid, q.size() != 0);
            chk("s_ready", s_ready, exp_rdy);
            if (q.size() != 0) begin
                chk("m_data", m_data, q[0][W-1:0]);
                chk("m_last", m_last, q[0][W]);
            end
            hs_p     = m_valid && m_ready;
            acc_p    = s_valid && s_ready;
            acc_keep = s_keep;
            acc_last = s_last;
            acc_data = s_data;
            cyc++;
            if (tp_on) begin
                if (m_valid) begin
                    vcnt++;
                    if (first_v < 0) first_v = cyc;
                end
                if (hs_p) last_hs = cyc;
            end
        end
    end

    always @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            q.delete();
        end else begin
            int hi;
            if (hs_p && q.size() > 0) void'(q.pop_front());
            if (acc_p) begin
                hi = -1;
                for (int i = 0; i < int'(R); i++) if (acc_keep[i]) hi = i;
                for (int i = 0; i < int'(R); i++)
                    if (acc_keep[i]) q.push_back({acc_last && (i == hi), acc_data[i]});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) m_ready = ($urandom_range(0, 9) < 7);
    end

    // Caller is 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic send(input logic [W-1:0] d0, input logic [W-1:0] d1,
                        input logic [R-1:0] k, input logic l);
        int n = 0;
        s_data[0] = d0;
        s_data[1] = d1;
        s_keep    = k;
        s_last    = l;
        s_valid   = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_data[0] = '0;
        s_data[1] = '0;
        // Reset held with random upstream activity.
        repeat (10) begin
            @(posedge clk);
            #1;
            s_data[0] = W'($urandom);
            s_data[1] = W'($urandom);
            s_keep    = R'($urandom);
            s_last    = 1'($urandom);
            s_valid   = 1'($urandom);
        end
        s_valid = 1'b0;
        s_keep  = '0;
        s_last  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Full beat: 0xA then 0xB with last.
        send(4'hA, 4'hB, 2'b11, 1'b1);
        @(negedge clk);
        chk("a_n1_data", m_data, 4'hA);
        chk("a_n1_last", m_last, 0);
        @(negedge clk);
        chk("a_n2_data", m_data, 4'hB);
        chk("a_n2_last", m_last, 1);
        chk("a_n2_ready", s_ready, EXP_RDY_N2);
        @(negedge clk);
        chk("a_n3_ready", s_ready, 1);
        chk("a_n3_valid", m_valid, 0);
        @(posedge clk);
        #1;

        // Sparse beats.
        send(4'h0, 4'h3, 2'b10, 1'b1);
        @(negedge clk);
        chk("sp1_data", m_data, 4'h3);
        chk("sp1_last", m_last, 1);
        @(posedge clk);
        #1;
        send(4'h5, 4'h0, 2'b01, 1'b0);
        @(negedge clk);
        chk("sp2_data", m_data, 4'h5);
        chk("sp2_last", m_last, 0);
        @(posedge clk);
        #1;
        drain();

        // Backpressure on the first word.
        send(4'hA, 4'hB, 2'b11, 1'b1);
        m_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_data", m_data, 4'hA);
            chk("bp_valid", m_valid, 1);
            chk("bp_last", m_last, 0);
            chk("bp_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_a", m_data, 4'hA);
        @(negedge clk);
        chk("bp_rel_b", m_data, 4'hB);
        chk("bp_rel_last", m_last, 1);
        @(posedge clk);
        #1;
        drain();

        // Zero-keep beat is swallowed.
        send(4'h7, 4'h7, 2'b00, 1'b0);
        @(negedge clk);
        chk("zk_no_valid", m_valid, 0);
        @(posedge clk);
        #1;
        send(4'h1, 4'h2, 2'b11, 1'b0);
        @(negedge clk);
        chk("zk_w0", m_data, 4'h1);
        @(negedge clk);
        chk("zk_w1", m_data, 4'h2);
        @(posedge clk);
        #1;
        drain();

        // Asynchronous reset right after 0xA handshakes.
        send(4'hA, 4'hB, 2'b11, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_valid", m_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Four back-to-back full beats.
        tp_on = 1;
        repeat (4) send(W'($urandom), W'($urandom), 2'b11, 1'b1);
        drain();
        tp_on = 0;
        chk("tp_valid_cycles", vcnt, 8);
        chk("tp_span", last_hs - first_v + 1, EXP_SPAN);

        // Randomized traffic with random backpressure.
        rand_rdy = 1;
        for (int b = 0; b < 300; b++) begin
            logic [R-1:0] k;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            k = R'($urandom);
            send(W'($urandom), W'($urandom), k, (k != '0) ? 1'($urandom) : 1'b0);
        end
        rand_rdy = 0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
